// File: rtl/rv_enc_pkg.sv
// Shared RV32I encoding definitions: request class codes, major opcodes
// (inst[6:2], same values the decoder matches on), fixed words and the
// field-level request struct carried through the encoder pipeline.
package rv_enc_pkg;

  typedef enum logic [3:0] {
    CLS_R      = 4'd0,
    CLS_IARITH = 4'd1,
    CLS_LOAD   = 4'd2,
    CLS_STORE  = 4'd3,
    CLS_BRANCH = 4'd4,
    CLS_JAL    = 4'd5,
    CLS_JALR   = 4'd6,
    CLS_LUI    = 4'd7,
    CLS_AUIPC  = 4'd8,
    CLS_ECALL  = 4'd9
  } enc_class_e;

  localparam logic [4:0] OP_OP     = 5'b01100;
  localparam logic [4:0] OP_OPIMM  = 5'b00100;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;

  localparam logic [31:0] NOP_WORD   = 32'h0000_0013;
  localparam logic [31:0] ECALL_WORD = 32'h0000_0073;

  // Class is kept as raw bits so illegal codes 10..15 survive to the packer.
  typedef struct packed {
    logic [3:0]  cls;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [31:0] imm;
  } enc_req_t;

  // True when v is representable as a w-bit two's-complement value.
  function automatic logic fits_signed(input logic signed [31:0] v, input int unsigned w);
    logic signed [31:0] hi;
    hi = v >>> (w - 1);
    return (hi == 32'sd0) || (hi == -32'sd1);
  endfunction

endpackage

// File: rtl/inst_field_pack.sv
// Combinational class+fields -> {inst, err} packer.
// Optional INST_ENC_RANGE_CHECK_EN: also flag immediates that do not fit
// their format (the word is still emitted with the immediate truncated).
module inst_field_pack
  import rv_enc_pkg::*;
(
  input  enc_req_t    req,
  output logic [31:0] inst,
  output logic        err
);

  logic [6:0] f7;
  logic       is_shift;
  logic       illegal;

  assign f7       = {1'b0, req.funct7b5, 5'b00000};
  assign is_shift = (req.funct3 == 3'b001) || (req.funct3 == 3'b101);

  // Field placement per class; unused fields stay zero.
  always_comb begin
    inst    = NOP_WORD;
    illegal = 1'b0;
    case (req.cls)
      CLS_R:      inst = {f7, req.rs2, req.rs1, req.funct3, req.rd, OP_OP, 2'b11};
      CLS_IARITH: begin
        if (is_shift)
          inst = {f7, req.imm[4:0], req.rs1, req.funct3, req.rd, OP_OPIMM, 2'b11};
        else
          inst = {req.imm[11:0], req.rs1, req.funct3, req.rd, OP_OPIMM, 2'b11};
      end
      CLS_LOAD:   inst = {req.imm[11:0], req.rs1, req.funct3, req.rd, OP_LOAD, 2'b11};
      CLS_STORE:  inst = {req.imm[11:5], req.rs2, req.rs1, req.funct3, req.imm[4:0],
                          OP_STORE, 2'b11};
      CLS_BRANCH: inst = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.funct3,
                          req.imm[4:1], req.imm[11], OP_BRANCH, 2'b11};
      CLS_JAL:    inst = {req.imm[20], req.imm[10:1], req.imm[11], req.imm[19:12],
                          req.rd, OP_JAL, 2'b11};
      CLS_JALR:   inst = {req.imm[11:0], req.rs1, 3'b000, req.rd, OP_JALR, 2'b11};
      CLS_LUI:    inst = {req.imm[31:12], req.rd, OP_LUI, 2'b11};
      CLS_AUIPC:  inst = {req.imm[31:12], req.rd, OP_AUIPC, 2'b11};
      CLS_ECALL:  inst = ECALL_WORD;
      default: begin
        inst    = NOP_WORD;
        illegal = 1'b1;
      end
    endcase
  end

`ifdef INST_ENC_RANGE_CHECK_EN
  logic signed [31:0] imm_s;
  logic               range_bad;

  assign imm_s = req.imm;

  // Immediate fit check per format.
  always_comb begin
    range_bad = 1'b0;
    case (req.cls)
      CLS_IARITH: range_bad = is_shift ? (|req.imm[11:5]) : !fits_signed(imm_s, 12);
      CLS_LOAD,
      CLS_JALR,
      CLS_STORE:  range_bad = !fits_signed(imm_s, 12);
      CLS_BRANCH: range_bad = !fits_signed(imm_s, 13) || req.imm[0];
      CLS_JAL:    range_bad = !fits_signed(imm_s, 21) || req.imm[0];
      CLS_LUI,
      CLS_AUIPC:  range_bad = |req.imm[11:0];
      default:    range_bad = 1'b0;
    endcase
  end

  assign err = illegal | range_bad;
`else
  assign err = illegal;
`endif

endmodule

// File: rtl/inst_encoder.sv
// Pipelined RV32I instruction encoder: valid/ready field requests in,
// packed 32-bit words tagged with sequential word addresses out.
// Optional INST_ENC_RANGE_CHECK_EN enables immediate range flagging in
// inst_field_pack.
module inst_encoder
  import rv_enc_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_class,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [2:0]        req_funct3,
  input  logic              req_funct7b5,
  input  logic [31:0]       req_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  enc_req_t          req_in;
  enc_req_t          req_p1;
  logic              vld_p1;
  logic              vld_p2;
  logic [31:0]       inst_p2;
  logic [ADDR_W-1:0] addr_p2;
  logic              err_p2;
  logic [ADDR_W-1:0] cnt;
  logic              s2_can_load;
  logic [31:0]       pk_inst;
  logic              pk_err;

  assign req_in = '{cls: req_class, rd: req_rd, rs1: req_rs1, rs2: req_rs2,
                    funct3: req_funct3, funct7b5: req_funct7b5, imm: req_imm};

  assign s2_can_load = !vld_p2 || out_ready;
  assign req_ready   = !flush && (!vld_p1 || s2_can_load);

  // ---- stage 1: accepted request ----
  // Stage-1 occupancy: refills whenever empty or draining into stage 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      vld_p1 <= 1'b0;
    else if (flush)
      vld_p1 <= 1'b0;
    else if (!vld_p1 || s2_can_load)
      vld_p1 <= req_valid;
  end

  // Stage-1 request fields, qualified by vld_p1.
  always_ff @(posedge clk) begin
    if (req_valid && req_ready)
      req_p1 <= req_in;
  end

  inst_field_pack u_pack (
    .req  (req_p1),
    .inst (pk_inst),
    .err  (pk_err)
  );

  // ---- stage 2: encoded word, address and error flag ----
  // Output register plus address counter; flush drops words and rewinds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      inst_p2 <= '0;
      addr_p2 <= '0;
      err_p2  <= 1'b0;
      cnt     <= BASE;
    end else if (flush) begin
      vld_p2 <= 1'b0;
      cnt    <= BASE;
    end else if (s2_can_load) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        inst_p2 <= pk_inst;
        err_p2  <= pk_err;
        addr_p2 <= cnt;
        cnt     <= cnt + ADDR_W'(1);
      end
    end
  end

  assign out_valid = vld_p2;
  assign out_inst  = inst_p2;
  assign out_addr  = addr_p2;
  assign out_err   = err_p2;

endmodule
